gecko_supervisor_arbiter: RTL and testbench

Shares the single supervisor memory port of the gecko core, which expects `std_mem_intf` request/response, between several supervisor masters. Typical masters are the AXI4 slave bridge and a debug/loader port. The block arbitrates requests with a locked round-robin scheme, records which requester owns each in-flight transaction, and routes in-order responses back to their owners. It sits between the supervisor masters and `gecko_micro` inside the compute top level.

---
 rtl/gecko_supervisor_arbiter_pkg.sv | 21 ++
 rtl/gecko_supervisor_arb_tracker.sv | 65 ++++++
 rtl/gecko_supervisor_arbiter.sv | 155 +++++++++++++++
 tb/tb_gecko_supervisor_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gecko_supervisor_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gecko_supervisor_arbiter_pkg: shared types for the supervisor    |
// | port arbiter.                              Revision: 1.0         |
// +------------------------------------------------------------------+
package gecko_supervisor_arbiter_pkg;

  localparam int GECKO_SUPERVISOR_MAX_REQ = 8;
  localparam int OWNER_W = $clog2(GECKO_SUPERVISOR_MAX_REQ);
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int WE_W    = 4;

  typedef logic [OWNER_W-1:0] gecko_supervisor_owner_t;

  function automatic int gecko_rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gecko_supervisor_arb_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gecko_supervisor_arb_tracker: in-order FIFO of request owners.   |
// |                                            Revision: 1.0         |
// +------------------------------------------------------------------+
module gecko_supervisor_arb_tracker
  import gecko_supervisor_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  gecko_supervisor_owner_t   data_i,
  output gecko_supervisor_owner_t   data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  gecko_supervisor_owner_t mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/gecko_supervisor_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gecko_supervisor_arbiter: locked round-robin sharing of the core |
// | supervisor port; GECKO_SUPERVISOR_ARB_FIXED_PRIORITY_EN selects  |
// | fixed lowest-index priority.               Revision: 1.0         |
// +------------------------------------------------------------------+
module gecko_supervisor_arbiter
  import gecko_supervisor_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_request_valid_i,
  output logic [NUM_REQ-1:0]       req_request_ready_o,
  input  logic [NUM_REQ-1:0]       req_request_read_enable_i,
  input  logic [NUM_REQ*WE_W-1:0]  req_request_write_enable_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_request_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_request_data_i,
  output logic [NUM_REQ-1:0]       req_response_valid_o,
  input  logic [NUM_REQ-1:0]       req_response_ready_i,
  output logic [NUM_REQ*DATA_W-1:0] req_response_data_o,
  output logic                     sup_request_valid_o,
  input  logic                     sup_request_ready_i,
  output logic                     sup_request_read_enable_o,
  output logic [WE_W-1:0]          sup_request_write_enable_o,
  output logic [ADDR_W-1:0]        sup_request_addr_o,
  output logic [DATA_W-1:0]        sup_request_data_o,
  input  logic                     sup_response_valid_i,
  output logic                     sup_response_ready_o,
  input  logic [DATA_W-1:0]        sup_response_data_i,
  output logic                     error
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_found;
  logic                    req_hs;
  logic                    rsp_pop;
  logic                    trk_full;
  logic                    trk_empty;
  logic [CNT_W-1:0]        trk_count;
  gecko_supervisor_owner_t trk_head;

  logic                    lock_valid_q;
  logic [IDX_W-1:0]        lock_idx_q;
  logic                    error_q, error_d;
`ifndef GECKO_SUPERVISOR_ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]        last_q;
`endif

  // Descending scans so the last hit is the highest-priority candidate.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    if (lock_valid_q) begin
      gnt_found = req_request_valid_i[lock_idx_q];
      gnt_idx   = lock_idx_q;
    end else begin
`ifdef GECKO_SUPERVISOR_ARB_FIXED_PRIORITY_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_request_valid_i[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = IDX_W'(i);
        end
      end
`else
      for (int i = NUM_REQ; i >= 1; i--) begin
        if (req_request_valid_i[gecko_rr_index(int'(last_q), i, NUM_REQ)]) begin
          gnt_found = 1'b1;
          gnt_idx   = IDX_W'(gecko_rr_index(int'(last_q), i, NUM_REQ));
        end
      end
`endif
    end
  end

  always_comb begin
    req_request_ready_o        = '0;
    sup_request_valid_o        = rst && gnt_found && !trk_full;
    sup_request_read_enable_o  = 1'b0;
    sup_request_write_enable_o = '0;
    sup_request_addr_o         = '0;
    sup_request_data_o         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(gnt_idx) == i) begin
        req_request_ready_o[i]     = rst && gnt_found && sup_request_ready_i && !trk_full;
        sup_request_read_enable_o  = req_request_read_enable_i[i];
        sup_request_write_enable_o = req_request_write_enable_i[i*WE_W +: WE_W];
        sup_request_addr_o         = req_request_addr_i[i*ADDR_W +: ADDR_W];
        sup_request_data_o         = req_request_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_hs = sup_request_valid_o && sup_request_ready_i;

  // With nothing in flight the core response is swallowed and flagged.
  always_comb begin
    req_response_valid_o = '0;
    req_response_data_o  = '0;
    sup_response_ready_o = rst;
    if (!trk_empty) begin
      sup_response_ready_o = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (int'(trk_head) == i) begin
          req_response_valid_o[i]              = rst && sup_response_valid_i;
          req_response_data_o[i*DATA_W +: DATA_W] = sup_response_data_i;
          sup_response_ready_o                 = rst && req_response_ready_i[i];
        end
      end
    end
    rsp_pop = !trk_empty && sup_response_valid_i && sup_response_ready_o;
    error_d = error_q || (trk_empty && sup_response_valid_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
      error_q      <= 1'b0;
`ifndef GECKO_SUPERVISOR_ARB_FIXED_PRIORITY_EN
      last_q       <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      lock_valid_q <= gnt_found && !req_hs;
      lock_idx_q   <= gnt_idx;
      error_q      <= error_d;
`ifndef GECKO_SUPERVISOR_ARB_FIXED_PRIORITY_EN
      if (req_hs) last_q <= gnt_idx;
`endif
    end
  end

  assign error = error_q;

  gecko_supervisor_arb_tracker #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_hs),
    .pop_i   (rsp_pop),
    .data_i  (OWNER_W'(gnt_idx)),
    .data_o  (trk_head),
    .full_o  (trk_full),
    .empty_o (trk_empty),
    .count_o (trk_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_gecko_supervisor_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gecko_supervisor_arbiter: directed self-checking bench.       |
// |                                            Revision: 1.0         |
// +------------------------------------------------------------------+
module tb_gecko_supervisor_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_re = '0;
  logic [7:0]  req_we = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [63:0] rsp_data;
  logic        sup_req_valid;
  logic        sup_req_ready = 1'b0;
  logic        sup_req_re;
  logic [3:0]  sup_req_we;
  logic [31:0] sup_req_addr;
  logic [31:0] sup_req_data;
  logic        sup_rsp_valid = 1'b0;
  logic        sup_rsp_ready;
  logic [31:0] sup_rsp_data = '0;
  logic        error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gecko_supervisor_arbiter #(
    .NUM_REQ         (2),
    .MAX_OUTSTANDING (4)
  ) u_dut (
    .clk                        (clk),
    .rst                        (rst),
    .req_request_valid_i        (req_valid),
    .req_request_ready_o        (req_ready),
    .req_request_read_enable_i  (req_re),
    .req_request_write_enable_i (req_we),
    .req_request_addr_i         (req_addr),
    .req_request_data_i         (req_data),
    .req_response_valid_o       (rsp_valid),
    .req_response_ready_i       (rsp_ready),
    .req_response_data_o        (rsp_data),
    .sup_request_valid_o        (sup_req_valid),
    .sup_request_ready_i        (sup_req_ready),
    .sup_request_read_enable_o  (sup_req_re),
    .sup_request_write_enable_o (sup_req_we),
    .sup_request_addr_o         (sup_req_addr),
    .sup_request_data_o         (sup_req_data),
    .sup_response_valid_i       (sup_rsp_valid),
    .sup_response_ready_o       (sup_rsp_ready),
    .sup_response_data_i        (sup_rsp_data),
    .error                      (error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_addr = {32'h0000_0200, 32'h0000_0100};
    req_data = {32'h1111_1111, 32'h0000_0000};
    req_re   = 2'b10;
    req_we   = {4'h0, 4'hF};
    rsp_ready = 2'b11;
    #1;
    chk("rst_sup_valid", 64'(sup_req_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_sup_rsp_ready", 64'(sup_rsp_ready), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_count", 64'(u_dut.u_tracker.count_o), 64'd0);

    // Round-robin: both valid, core always ready.
    tick();
    rst = 1'b1; req_valid = 2'b11; sup_req_ready = 1'b1;
    #1;
    chk("rr0_addr", 64'(sup_req_addr), 64'h100);
    chk("rr0_ready", 64'(req_ready), 64'b01);
    chk("rr0_we", 64'(sup_req_we), 64'hF);
    tick(); #1;
    chk("rr1_addr", 64'(sup_req_addr), 64'h200);
    chk("rr1_ready", 64'(req_ready), 64'b10);
    chk("rr1_re", 64'(sup_req_re), 64'd1);
    tick(); #1;
    chk("rr2_addr", 64'(sup_req_addr), 64'h100);
    chk("rr2_ready", 64'(req_ready), 64'b01);
    tick(); #1;
    chk("rr3_addr", 64'(sup_req_addr), 64'h200);
    chk("rr3_ready", 64'(req_ready), 64'b10);

    // Four outstanding: full, a pop in the same cycle does not free a slot.
    tick(); #1;
    chk("full_count", 64'(u_dut.u_tracker.count_o), 64'd4);
    chk("full_sup_valid", 64'(sup_req_valid), 64'd0);
    chk("full_ready", 64'(req_ready), 64'b00);
    sup_rsp_valid = 1'b1; sup_rsp_data = 32'h0000_00A0;
    #1;
    chk("full_pop_rsp_valid", 64'(rsp_valid), 64'b01);
    chk("full_pop_rsp_data0", 64'(rsp_data[31:0]), 64'hA0);
    chk("full_pop_sup_rsp_ready", 64'(sup_rsp_ready), 64'd1);
    chk("full_pop_same_cycle_ready", 64'(req_ready), 64'b00);

    tick();
    sup_rsp_data = 32'h0000_00B1;
    #1;
    chk("after_pop_rsp_valid", 64'(rsp_valid), 64'b10);
    chk("after_pop_rsp_data1", 64'(rsp_data[63:32]), 64'hB1);
    chk("fifth_ready", 64'(req_ready), 64'b01);
    chk("fifth_addr", 64'(sup_req_addr), 64'h100);

    // Response backpressure: owner 0 stalls two cycles.
    tick();
    req_valid = 2'b00; rsp_ready = 2'b10; sup_rsp_data = 32'h0000_00C0;
    #1;
    chk("bp0_rsp_valid", 64'(rsp_valid), 64'b01);
    chk("bp0_sup_rsp_ready", 64'(sup_rsp_ready), 64'd0);
    tick(); #1;
    chk("bp1_sup_rsp_ready", 64'(sup_rsp_ready), 64'd0);
    chk("bp1_count", 64'(u_dut.u_tracker.count_o), 64'd3);
    tick();
    rsp_ready = 2'b11;
    #1;
    chk("bp2_sup_rsp_ready", 64'(sup_rsp_ready), 64'd1);
    tick(); #1;
    chk("bp_pop_count", 64'(u_dut.u_tracker.count_o), 64'd2);
    sup_rsp_data = 32'h0000_00D1;
    #1;
    chk("drain0_rsp_valid", 64'(rsp_valid), 64'b10);
    tick(); #1;
    chk("drain1_rsp_valid", 64'(rsp_valid), 64'b01);
    tick(); #1;
    chk("drained_count", 64'(u_dut.u_tracker.count_o), 64'd0);

    // Unexpected response with an empty tracker.
    sup_rsp_data = 32'hDEAD_BEEF;
    #1;
    chk("unexp_rsp_valid", 64'(rsp_valid), 64'b00);
    chk("unexp_sup_rsp_ready", 64'(sup_rsp_ready), 64'd1);
    tick();
    sup_rsp_valid = 1'b0;
    #1;
    chk("unexp_error_set", 64'(error), 64'd1);
    tick(); #1;
    chk("unexp_error_sticky", 64'(error), 64'd1);

    // Lock: requester 1 granted while the core stalls; requester 0 joins.
    req_addr = {32'h0000_0300, 32'h0000_0400};
    req_valid = 2'b10; sup_req_ready = 1'b0;
    #1;
    chk("lock0_addr", 64'(sup_req_addr), 64'h300);
    chk("lock0_ready", 64'(req_ready), 64'b00);
    tick();
    req_valid = 2'b11;
    #1;
    chk("lock1_addr", 64'(sup_req_addr), 64'h300);
    chk("lock1_valid", 64'(sup_req_valid), 64'd1);
    tick(); #1;
    chk("lock2_addr", 64'(sup_req_addr), 64'h300);
    tick();
    sup_req_ready = 1'b1;
    #1;
    chk("lock_release_ready", 64'(req_ready), 64'b10);
    tick(); #1;
    chk("lock_next_addr", 64'(sup_req_addr), 64'h400);
    chk("lock_next_ready", 64'(req_ready), 64'b01);
    tick(); #1;
    chk("pre_rst_count", 64'(u_dut.u_tracker.count_o), 64'd2);

    // Reset with two requests outstanding.
    rst = 1'b0;
    #1;
    chk("mid_rst_sup_valid", 64'(sup_req_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'b00);
    chk("mid_rst_sup_rsp_ready", 64'(sup_rsp_ready), 64'd0);
    chk("mid_rst_error", 64'(error), 64'd0);
    chk("mid_rst_count", 64'(u_dut.u_tracker.count_o), 64'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_addr", 64'(sup_req_addr), 64'h400);
    chk("post_rst_ready", 64'(req_ready), 64'b01);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'b00);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
